// File: rtl/hexa_pkg.sv
// hexa_pkg: flit format, port offsets and shared types for the hexa mesh
package hexa_pkg;
    localparam int FLIT_W  = 32;
    localparam int COORD_W = 4;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 30;
    localparam logic [1:0] FLIT_IDLE = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;
    localparam int TYPE_LSB  = 30;
    localparam int DST_X_LSB = 26;
    localparam int DST_Y_LSB = 22;
    localparam int SRC_X_LSB = 18;
    localparam int SRC_Y_LSB = 14;
    localparam int LEN_LSB   = 10;
    localparam int PORT_XPOS = 0;
    localparam int PORT_XNEG = 1;
    localparam int PORT_YPOS = 2;
    localparam int PORT_YNEG = 3;
    localparam int PORT_PE   = 4;
    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAYLOAD} inj_state_e;
    function automatic logic [FLIT_W-1:0] make_head(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] sx,
        input logic [COORD_W-1:0] sy,
        input logic [LEN_W-1:0]   len
    );
        return (FLIT_W'(FLIT_HEAD) << TYPE_LSB) | (FLIT_W'(dx) << DST_X_LSB) |
               (FLIT_W'(dy) << DST_Y_LSB) | (FLIT_W'(sx) << SRC_X_LSB) |
               (FLIT_W'(sy) << SRC_Y_LSB) | (FLIT_W'(len) << LEN_LSB);
    endfunction
endpackage

// File: rtl/hexa_pe_injector_if.sv
// hexa_pe_injector_if: PE message/payload handshake and router pe channel bundle
interface hexa_pe_injector_if import hexa_pkg::*; #(parameter int CRT_W = 3);
    logic                 msg_valid;
    logic                 msg_ready;
    logic [COORD_W-1:0]   msg_dst_x;
    logic [COORD_W-1:0]   msg_dst_y;
    logic [LEN_W-1:0]     msg_len;
    logic                 data_valid;
    logic                 data_ready;
    logic [DATA_W-1:0]    data_in;
    logic                 credit_in;
    logic [FLIT_W-1:0]    channel_out;
    logic [CRT_W-1:0]     credits;
    logic                 err_zero_len;
    logic                 err_credit_ovf;
    modport master (
        output msg_valid, msg_dst_x, msg_dst_y, msg_len, data_valid, data_in, credit_in,
        input  msg_ready, data_ready, channel_out, credits, err_zero_len, err_credit_ovf
    );
    modport slave (
        input  msg_valid, msg_dst_x, msg_dst_y, msg_len, data_valid, data_in, credit_in,
        output msg_ready, data_ready, channel_out, credits, err_zero_len, err_credit_ovf
    );
endinterface

// File: rtl/hexa_credit_counter.sv
// hexa_credit_counter: saturating credit counter with sticky overflow flag
module hexa_credit_counter #(
    parameter int BUFFER_DEPTH = 4,
    parameter int CRT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send,
    input  logic             credit_in,
    output logic [CRT_W-1:0] count,
    output logic             can_send,
    output logic             ovf
);
    logic lost;
    assign can_send = count != '0;
    assign lost     = credit_in && !send && count == CRT_W'(BUFFER_DEPTH);
    // a credit arriving at full count with no send is dropped and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CRT_W'(BUFFER_DEPTH);
            ovf   <= 1'b0;
        end else begin
            count <= count - CRT_W'(send) + CRT_W'(credit_in && !lost);
            ovf   <= ovf || lost;
        end
    end
endmodule

// File: rtl/hexa_pe_injector.sv
// hexa_pe_injector: packetizes PE messages into head/body/tail flits for the router pe port
module hexa_pe_injector import hexa_pkg::*; #(
    parameter int XCOR         = 2,
    parameter int YCOR         = 2,
    parameter int BUFFER_DEPTH = 4,
    parameter int CRT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input logic               clk,
    input logic               rst,
    hexa_pe_injector_if.slave bus
);
    inj_state_e         state;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   remaining;
    logic               can_send;
    logic               take_word;
    logic               send;
    assign bus.msg_ready  = state == S_IDLE;
    assign bus.data_ready = state == S_PAYLOAD && can_send;
    assign take_word      = bus.data_valid && bus.data_ready;
    assign send           = (state == S_HEAD && can_send) || take_word;
    hexa_credit_counter #(.BUFFER_DEPTH(BUFFER_DEPTH), .CRT_W(CRT_W)) u_credit (
        .clk      (clk),
        .rst      (rst),
        .send     (send),
        .credit_in(bus.credit_in),
        .count    (bus.credits),
        .can_send (can_send),
        .ovf      (bus.err_credit_ovf)
    );
    // packet FSM; channel_out is registered and falls back to idle every cycle without a send
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            dst_x            <= '0;
            dst_y            <= '0;
            len              <= '0;
            remaining        <= '0;
            bus.channel_out  <= '0;
            bus.err_zero_len <= 1'b0;
        end else begin
            bus.channel_out <= '0;
            case (state)
                S_IDLE: if (bus.msg_valid) begin
                    if (bus.msg_len != '0) begin
                        dst_x     <= bus.msg_dst_x;
                        dst_y     <= bus.msg_dst_y;
                        len       <= bus.msg_len;
                        remaining <= bus.msg_len;
                        state     <= S_HEAD;
                    end else begin
                        bus.err_zero_len <= 1'b1;
                    end
                end
                S_HEAD: if (can_send) begin
                    bus.channel_out <= make_head(dst_x, dst_y, COORD_W'(XCOR), COORD_W'(YCOR), len);
                    state           <= S_PAYLOAD;
                end
                S_PAYLOAD: if (take_word) begin
                    bus.channel_out <= {((remaining == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY), bus.data_in};
                    remaining       <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hexa_pe_injector.sv
// tb_hexa_pe_injector: directed scoreboard bench for hexa_pe_injector
module tb_hexa_pe_injector;
    localparam int CW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    hexa_pe_injector_if #(.CRT_W(CW)) bus();
    hexa_pe_injector #(.XCOR(2), .YCOR(2), .BUFFER_DEPTH(4), .CRT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    logic [31:0] exp_q[$];
    int errors = 0, checks = 0, cyc = 0, flits = 0, head_cyc = 0, last_cyc = 0, f0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.channel_out !== 32'h0) begin
            flits++;
            last_cyc = cyc;
            if (bus.channel_out[31:30] == 2'b01) head_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_flit", bus.channel_out, 32'h0);
            else chk("flit", bus.channel_out, exp_q.pop_front());
        end
    end

    function automatic logic [31:0] head(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
        return {2'b01, dx, dy, 4'd2, 4'd2, len, 10'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
        bus.msg_valid = 1'b1;
        bus.msg_dst_x = dx;
        bus.msg_dst_y = dy;
        bus.msg_len   = len;
        @(negedge clk);
        chk("msg_ready", 32'(bus.msg_ready), 1);
        step();
        bus.msg_valid = 1'b0;
        if (len != 0) exp_q.push_back(head(dx, dy, len));
    endtask

    task automatic send_word(input logic [29:0] d, input logic last);
        int n = 0;
        bus.data_valid = 1'b1;
        bus.data_in    = d;
        exp_q.push_back({(last ? 2'b11 : 2'b10), d});
        @(negedge clk);
        while (!bus.data_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("word_accept", 32'(bus.data_ready), 1);
        step();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.msg_valid = 1'b0;
        bus.msg_dst_x = '0;
        bus.msg_dst_y = '0;
        bus.msg_len   = '0;
        bus.data_valid = 1'b0;
        bus.data_in   = '0;
        bus.credit_in = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_channel", bus.channel_out, 0);
        chk("rst_credits", 32'(bus.credits), 4);
        chk("rst_msg_ready", 32'(bus.msg_ready), 1);
        chk("rst_data_ready", 32'(bus.data_ready), 0);
        chk("rst_err_zero", 32'(bus.err_zero_len), 0);
        chk("rst_err_ovf", 32'(bus.err_credit_ovf), 0);
        step();

        send_msg(4'd3, 4'd1, 4'd2);
        send_word(30'h1, 1'b0);
        send_word(30'h2, 1'b1);
        bus.data_valid = 1'b0;
        wait_drain();
        chk("t1_span", last_cyc - head_cyc, 2);
        chk("t1_credits", 32'(bus.credits), 1);

        bus.credit_in = 1'b1;
        repeat (3) step();
        bus.credit_in = 1'b0;
        @(negedge clk);
        chk("refill_credits", 32'(bus.credits), 4);
        chk("refill_ovf", 32'(bus.err_credit_ovf), 0);
        step();

        f0 = flits;
        send_msg(4'd5, 4'd6, 4'd5);
        send_word(30'h11, 1'b0);
        send_word(30'h12, 1'b0);
        send_word(30'h13, 1'b0);
        bus.data_in = 30'h14;
        repeat (4) step();
        @(negedge clk);
        chk("t2_stall_flits", flits - f0, 4);
        chk("t2_stall_credits", 32'(bus.credits), 0);
        chk("t2_stall_ready", 32'(bus.data_ready), 0);
        chk("t2_stall_idle", bus.channel_out, 0);
        step();
        bus.credit_in = 1'b1;
        step();
        bus.credit_in = 1'b0;
        send_word(30'h14, 1'b0);
        bus.data_in = 30'h15;
        repeat (3) step();
        @(negedge clk);
        chk("t2_one_more", flits - f0, 5);
        chk("t2_credits0", 32'(bus.credits), 0);
        chk("t2_idle2", bus.channel_out, 0);
        step();
        bus.credit_in = 1'b1;
        step();
        bus.credit_in = 1'b0;
        send_word(30'h15, 1'b1);
        bus.data_valid = 1'b0;
        wait_drain();
        chk("t2_total", flits - f0, 6);
        bus.credit_in = 1'b1;
        repeat (4) step();
        bus.credit_in = 1'b0;
        @(negedge clk);
        chk("t2_refill", 32'(bus.credits), 4);
        chk("t2_refill_ovf", 32'(bus.err_credit_ovf), 0);
        step();

        send_msg(4'd7, 4'd0, 4'd9);
        bus.credit_in  = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = '0;
        step();
        for (int i = 1; i <= 9; i++) begin
            bus.data_in = 30'(i + 32);
            exp_q.push_back({((i == 9) ? 2'b11 : 2'b10), 30'(i + 32)});
            @(negedge clk);
            chk("t3_credits", 32'(bus.credits), 4);
            chk("t3_ready", 32'(bus.data_ready), 1);
            step();
        end
        bus.credit_in  = 1'b0;
        bus.data_valid = 1'b0;
        wait_drain();
        chk("t3_span", last_cyc - head_cyc, 9);
        chk("t3_credits_end", 32'(bus.credits), 4);
        chk("t3_ovf", 32'(bus.err_credit_ovf), 0);

        f0 = flits;
        send_msg(4'd1, 4'd1, 4'd0);
        @(negedge clk);
        chk("t4_err_zero", 32'(bus.err_zero_len), 1);
        chk("t4_msg_ready", 32'(bus.msg_ready), 1);
        step();
        repeat (3) step();
        @(negedge clk);
        chk("t4_no_flit", flits - f0, 0);
        chk("t4_err_sticky", 32'(bus.err_zero_len), 1);
        step();

        bus.credit_in = 1'b1;
        step();
        bus.credit_in = 1'b0;
        @(negedge clk);
        chk("t5_credits", 32'(bus.credits), 4);
        chk("t5_ovf", 32'(bus.err_credit_ovf), 1);
        step();

        send_msg(4'd0, 4'd3, 4'd4);
        send_word(30'h2A, 1'b0);
        send_word(30'h2B, 1'b0);
        bus.data_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_channel", bus.channel_out, 0);
        chk("t6_credits", 32'(bus.credits), 4);
        chk("t6_msg_ready", 32'(bus.msg_ready), 1);
        chk("t6_err_zero", 32'(bus.err_zero_len), 0);
        chk("t6_err_ovf", 32'(bus.err_credit_ovf), 0);
        chk("t6_queue", exp_q.size(), 0);
        step();
        send_msg(4'd2, 4'd2, 4'd1);
        send_word(30'h3FFF_FFFF, 1'b1);
        bus.data_valid = 1'b0;
        wait_drain();
        chk("t6_span", last_cyc - head_cyc, 1);
        chk("t6_credits_end", 32'(bus.credits), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
